rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one single-user resource among eight requesters, using priority encoding from a rotating start point. It sits between the request lines and the shared resource. It issues one-hot grants with a binary grant index matching the 8-to-3 encoder's output format. A hold-limit counter reclaims the resource from any requester that keeps it longer than a programmable limit.

---
 rtl/rr_arbiter8.sv | 102 ++++++++++
 tb/tb_rr_arbiter8.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with one-hot + binary grant outputs and a
// programmable hold limit that reclaims the resource from a lingering owner.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [0:0] state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] grant_reg, grant_next;
  logic [2:0] grant_id_reg, grant_id_next;
  logic       timeout_reg, timeout_next;

  logic [7:0] rot;
  logic [2:0] offset;
  logic [2:0] winner;

  // rot[k] is the request of the requester k places after ptr, so the lowest
  // set bit of rot is the next winner in round-robin order.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) offset = 3'(i);
    end
    winner = ptr_reg + offset;
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_next     = hold_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          grant_next    = 8'b1 << winner;
          grant_id_next = winner;
          hold_next     = 8'd1;
          ptr_next      = winner + 3'd1;
        end
      end
      default: begin
        if (rel || !req[grant_id_reg]) begin
          state_next = IDLE;
          grant_next = 8'h00;
        end else if ((HOLD_LIMIT != 8'd0) && (hold_reg == HOLD_LIMIT)) begin
          state_next   = IDLE;
          grant_next   = 8'h00;
          timeout_next = 1'b1;
        end else if (hold_reg != 8'hFF) begin
          hold_next = hold_reg + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      hold_reg     <= 8'd0;
      grant_reg    <= 8'h00;
      grant_id_reg <= 3'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_reg     <= hold_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = grant_id_reg;
  assign grant_valid = (state_reg == GRANT);
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): directed vector table, rotation sequence,
// then randomized traffic checked against a behavioural arbitration model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       l;
    logic [7:0] eg;
    logic [2:0] eid;
    logic       ev;
    logic       et;
  } vec_t;

  vec_t vecs[29];

  // Behavioural model: owner < 0 means nobody holds the resource.
  int   m_owner, m_ptr, m_hold, m_id;
  logic m_to;

  task automatic model_step(input logic r, input logic [7:0] q, input logic l);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_id = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (q[idx] && m_owner < 0) begin
          m_owner = idx; m_id = idx; m_hold = 1; m_ptr = (idx + 1) % 8;
        end
      end
    end else begin
      m_to = 1'b0;
      if (l || !q[m_owner]) begin
        m_owner = -1;
      end else if (MH != 0 && m_hold == MH) begin
        m_owner = -1;
        m_to = 1'b1;
      end else if (m_hold < 255) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    return {g, 3'(m_id), (m_owner >= 0), m_to};
  endfunction

  task automatic apply(input logic r, input logic [7:0] q, input logic l);
    rst = r; req = q; rel = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = {grant, grant_id, grant_valid, timeout};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, need grant=%b id=%0d valid=%b timeout=%b",
               name, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // reset with all requests up
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    // single requester 2, then release; release while idle is ignored
    vecs[4]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    // grant to 6 leaves ptr=7, so 0 beats 6; then ptr=1 lets 6 beat 7
    vecs[7]  = '{1'b0, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'hC0, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
    // hold limit: four grant cycles, one timeout idle cycle, regrant
    vecs[13] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h10, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    // release on the limit cycle wins without a timeout
    vecs[19] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0};
    // owner drops its request mid-grant
    vecs[23] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 8'h20, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
    // reset during a grant, then ptr restarts at 0
    vecs[25] = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[26] = '{1'b1, 8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 29; i++) begin
      apply(vecs[i].r, vecs[i].q, vecs[i].l);
      check($sformatf("vec%0d", i), {vecs[i].eg, vecs[i].eid, vecs[i].ev, vecs[i].et});
    end

    // rotation: all requesting, release every grant -> ids 0..7,0 with idle gaps
    apply(1'b1, 8'hFF, 1'b0);
    check("rot_reset", 13'd0);
    for (int k = 0; k < 9; k++) begin
      logic [2:0] id;
      id = 3'(k % 8);
      apply(1'b0, 8'hFF, 1'b1);
      check($sformatf("rot_grant%0d", k), {8'(1 << id), id, 1'b1, 1'b0});
      apply(1'b0, 8'hFF, 1'b1);
      check($sformatf("rot_idle%0d", k), {8'h00, id, 1'b0, 1'b0});
    end

    // randomized traffic against the model
    model_step(1'b1, 8'h00, 1'b0);
    apply(1'b1, 8'h00, 1'b0);
    check("rnd_reset", model_out());
    for (int n = 0; n < 3000; n++) begin
      logic       r, l;
      logic [7:0] q;
      r = ($urandom_range(99) == 0);
      q = (n % 500 < 250) ? 8'($urandom) : 8'($urandom & $urandom);
      l = ($urandom_range(4) == 0);
      model_step(r, q, l);
      apply(r, q, l);
      check($sformatf("rnd%0d", n), model_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
